// File: rtl/tiny45_alu_pkg.sv
// tiny45_alu_pkg: shared constants for the nibble-serial ALU.
// Defines the {alt, funct3} opcode encodings, the nibble count of a 32-bit
// operation, the controller state enum and small opcode-decode helpers.
// The WB state exists only when TINY45_ALU_CMP_EN is defined.
package tiny45_alu_pkg;

  // A 32-bit word is processed as 8 nibbles, LSB first
  localparam int         NIBBLES     = 8;
  localparam logic [2:0] LAST_NIBBLE = 3'(NIBBLES - 1);

  // Opcode encodings: {alt, funct3}
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef TINY45_ALU_CMP_EN
    , ST_WB = 2'd2
`endif
  } state_t;

  // Ops that run the adder as a subtractor (a + ~b + 1)
  function automatic logic op_is_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  // Set-less-than ops, resolved at the last nibble
  function automatic logic op_is_cmp(input logic [3:0] op);
    return (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  // Bitwise ops
  function automatic logic op_is_logic(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_OR) || (op == OP_AND);
  endfunction

  // Ops whose RUN-phase nibbles are written straight to rd
  function automatic logic op_writes(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || op_is_logic(op);
  endfunction

endpackage

// File: rtl/tiny45_nibble_adder.sv
// tiny45_nibble_adder: combinational 4-bit ripple adder with carry in/out.
// Built from a generated chain of full adders so the carry path is explicit.
module tiny45_nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling upward
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[4];

endmodule

// File: rtl/tiny45_alu.sv
// tiny45_alu: nibble-serial ALU stage between the 4-bit register-file read
// ports and the write port. One nibble per clock, LSB first, indexed by the
// shared nibble counter. Carry and the A==B accumulator ride across the
// 8 nibbles; result/wr_en are combinational for same-cycle writeback.
// Optional feature macro: TINY45_ALU_CMP_EN enables SLT/SLTU with an 8-cycle
// WB pass writing the compare bit; without it those codes act as reserved.
module tiny45_alu
  import tiny45_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [2:0] counter,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       wr_en,
  output logic       cmp,
  output logic       eq,
  output logic       done
);

  state_t     state_reg, state_next;
  logic       carry_reg, carry_next;
  logic       eq_acc_reg, eq_acc_next;
  logic       eq_reg, eq_next;

  logic       first_nibble;
  logic       last_nibble;
  logic       run_cycle;
  logic       sub;
  logic [3:0] b_eff;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       nib_eq;

`ifdef TINY45_ALU_CMP_EN
  logic       cmp_reg, cmp_next;
  logic       op_cmp;
  logic       slt_lt;
  logic       sltu_lt;
`endif

  assign first_nibble = (counter == 3'd0);
  assign last_nibble  = (counter == LAST_NIBBLE);

  // A nibble is processed in RUN, and also in the IDLE cycle that accepts start
  assign run_cycle = (state_reg == ST_RUN) ||
                     ((state_reg == ST_IDLE) && start && first_nibble);

  // Subtraction is a + ~b + 1: the +1 enters as carry-in on the first nibble
  assign sub    = op_is_sub(op);
  assign b_eff  = sub ? ~b : b;
  assign cin    = first_nibble ? sub : carry_reg;
  assign nib_eq = (a == b);

  tiny45_nibble_adder u_adder (
    .a    (a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

`ifdef TINY45_ALU_CMP_EN
  assign op_cmp = op_is_cmp(op);
  // Signed: differing signs decide directly, otherwise the sign of a-b
  assign slt_lt  = (a[3] ^ b[3]) ? a[3] : sum[3];
  // Unsigned: a borrow out of the top nibble means a < b
  assign sltu_lt = ~cout;
`endif

  // Next-state, arithmetic state update and writeback outputs
  always_comb begin
    state_next  = state_reg;
    carry_next  = carry_reg;
    eq_acc_next = eq_acc_reg;
    eq_next     = eq_reg;
`ifdef TINY45_ALU_CMP_EN
    cmp_next    = cmp_reg;
`endif
    result      = 4'h0;
    wr_en       = 1'b0;
    done        = 1'b0;

    if (run_cycle) begin
      state_next  = ST_RUN;
      carry_next  = cout;
      eq_acc_next = first_nibble ? nib_eq : (eq_acc_reg & nib_eq);

      case (op)
        OP_ADD, OP_SUB: result = sum;
        OP_XOR:         result = a ^ b;
        OP_OR:          result = a | b;
        OP_AND:         result = a & b;
        default:        result = 4'h0;
      endcase
      wr_en = op_writes(op);

      if (last_nibble) begin
        eq_next = eq_acc_reg & nib_eq;
`ifdef TINY45_ALU_CMP_EN
        if (op_cmp) begin
          cmp_next   = (op == OP_SLT) ? slt_lt : sltu_lt;
          state_next = ST_WB;
        end else begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end
`else
        state_next = ST_IDLE;
        done       = 1'b1;
`endif
      end
    end
`ifdef TINY45_ALU_CMP_EN
    else if (state_reg == ST_WB) begin
      // Second pass writes the zero-extended compare bit into rd
      wr_en  = 1'b1;
      result = first_nibble ? {3'b000, cmp_reg} : 4'h0;
      if (last_nibble) begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
    end
`endif
  end

  // State and cross-nibble registers, asynchronously cleared
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= ST_IDLE;
      carry_reg  <= 1'b0;
      eq_acc_reg <= 1'b0;
      eq_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      carry_reg  <= carry_next;
      eq_acc_reg <= eq_acc_next;
      eq_reg     <= eq_next;
    end
  end

`ifdef TINY45_ALU_CMP_EN
  // Compare result register, updated only at the last nibble of SLT/SLTU
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_reg <= 1'b0;
    end else begin
      cmp_reg <= cmp_next;
    end
  end

  assign cmp = cmp_reg;
`else
  assign cmp = 1'b0;
`endif

  assign eq = eq_reg;

endmodule

// File: doc/tiny45_alu.md
# tiny45_alu

Nibble-serial ALU stage for the tiny45 RV32E core, sitting directly between the 4-bit register-file read ports and its write port. Consumes one operand nibble per clock (LSB first, indexed by the shared 3-bit nibble counter), produces one result nibble per clock for writeback, and carries arithmetic state (carry, equality, signed/unsigned compare) across the 8 nibbles of a 32-bit operation. Compare ops (SLT/SLTU) are resolved at nibble 7 and written back in a second 8-cycle pass.

## Interface
Parameters:
- none (fixed 32-bit datapath, 4-bit slice, 3-bit counter)

Ports:
- clk  in  1  core clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  begin an operation; accepted only in IDLE with counter==0
- op  in  4  {alt, funct3}: 0000 ADD, 1000 SUB, 0100 XOR, 0110 OR, 0111 AND, 0010 SLT, 0011 SLTU; all other codes reserved
- counter  in  3  current nibble index, increments by 1 every clock, wraps 7->0
- a  in  4  operand A nibble (rs1 read port)
- b  in  4  operand B nibble (rs2 read port or immediate nibble)
- result  out  4  result nibble for rd write port (combinational)
- wr_en  out  1  rd write enable for this nibble
- cmp  out  1  registered compare result of last SLT/SLTU
- eq  out  1  registered A==B flag of last operation
- done  out  1  one-cycle pulse on the last nibble of an operation

## Operation
- States: IDLE, RUN, WB (WB only with compare feature compiled in).
- IDLE: result=0, wr_en=0. start && counter==0 -> RUN, first nibble processed in that same cycle. start with counter!=0 ignored.
- RUN: for each nibble, sum = a + (sub ? ~b : b) + cin; cin = sub at counter 0, else carry register. sub = op is SUB, SLT or SLTU. carry register <= carry-out every RUN cycle.
- result: ADD/SUB -> sum[3:0]; XOR/OR/AND -> bitwise; SLT/SLTU -> 0; reserved -> 0. wr_en=1 in RUN for ADD/SUB/logic; wr_en=0 for compares and reserved.
- eq accumulator: cleared at counter 0 (eq_acc = (a==b)), ANDed each nibble; latched into eq at counter 7.
- At counter 7 in RUN: cmp <= SLT ? (a[3]^b[3] ? a[3] : sum[3]) : ~carry_out (SLTU); other ops leave cmp unchanged. Compare op -> WB; else -> IDLE with done=1.
- WB: result = {3'b0, cmp} at counter 0, else 0; wr_en=1 all 8 cycles; done=1 at counter 7, then IDLE.
- start during RUN/WB ignored.

## Timing
- Reset values: state IDLE, carry 0, eq_acc 0, cmp 0, eq 0; outputs result 0, wr_en 0, done 0.
- result/wr_en are combinational from a, b, op, counter, state, carry: zero-latency, same-cycle write into register file.
- Non-compare op: 8 cycles start-to-done. Compare op: 16 cycles (8 RUN + 8 WB).
- cmp and eq valid from the cycle after counter 7 of RUN; held until next compare/op end.
- Carry wrap-around: carry-out at counter 7 is discarded for ADD/SUB results (mod 2^32).
- rstn assertion mid-RUN/WB: immediate return to IDLE, no further wr_en, no done pulse.
- op, a, b sampled per cycle; op must be stable from start through done.

## Configuration
- TINY45_ALU_CMP_EN defined: SLT/SLTU supported, WB state present, cmp as above.
- Undefined: SLT/SLTU treated as reserved (result 0, wr_en 0, 8-cycle op with done at counter 7), no WB state, cmp tied 0. eq unaffected.

## Structure
- Package tiny45_alu_pkg: op encoding constants, state enum, nibble-count constant (8).
- Sub-module tiny45_nibble_adder: combinational 4-bit add with cin/cout, instantiated once.

## Test plan
- ADD 0x0000_0001 + 0xFFFF_FFFF -> result nibbles all 0, wr_en=1 x8, done at counter 7, eq=0.
- SUB 5 - 7 -> result 0xFFFF_FFFE (nibble 0 = 0xE, rest 0xF); SUB 0x1234_5678 - same -> 0, eq=1.
- SLT 0xFFFF_FFFF vs 1 -> cmp=1, WB writes nibble0=1 then 0s, done 16 cycles after start; SLTU same -> cmp=0, nibble0=0.
- XOR 0xA5A5_A5A5 ^ 0xFFFF_0000 -> 0x5A5A_A5A5; AND/OR spot values.
- start asserted at counter 3 -> ignored, wr_en stays 0; next start at counter 0 accepted.
- rstn low at counter 4 of RUN -> wr_en 0 immediately, cmp/eq 0, no done; op without CMP_EN: SLT -> wr_en 0, done at 8 cycles.
